// File: rtl/gsm_uart_tx.sv
// gsm_uart_tx: FIFO-buffered UART transmitter for the GSM alert path, 8N1 by default.
// Define GSM_UART_TX_PARITY_EN to insert an even-parity bit after the data (8E1).
module gsm_uart_tx #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_txd,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [DIV_W-1:0] BAUD_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef GSM_UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [DIV_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_q;
`ifdef GSM_UART_TX_PARITY_EN
  logic             parity_q;
`endif

  logic       full;
  logic       push;
  logic       pop;
  logic       baud_last;
  logic [7:0] rd_data;

  // FIFO handshake; a pop happens when the line is free to start a new frame
  always_comb begin
    full      = (count == FULL_CNT);
    push      = tx_valid && !full;
    baud_last = (baud_cnt == BAUD_LAST);
    pop       = (count != '0) && ((state == IDLE) || ((state == STOP) && baud_last));
    rd_data   = mem[rd_ptr];
  end

  assign tx_ready = !full;
  assign busy     = (state != IDLE) || (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Drop-on-full is judged on the pre-edge occupancy, even if a pop frees a slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= tx_valid && full;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer; uart_txd is loaded with the level of the bit being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      uart_txd <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
`ifdef GSM_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      baud_cnt <= baud_cnt + DIV_W'(1);
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          uart_txd <= 1'b1;
          if (pop) begin
            shift_q  <= rd_data;
`ifdef GSM_UART_TX_PARITY_EN
            parity_q <= ^rd_data;
`endif
            bit_cnt  <= '0;
            state    <= START;
            uart_txd <= 1'b0;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= DATA;
            uart_txd <= shift_q[0];
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            shift_q  <= {1'b0, shift_q[7:1]};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef GSM_UART_TX_PARITY_EN
              state    <= PARITY;
              uart_txd <= parity_q;
`else
              state    <= STOP;
              uart_txd <= 1'b1;
`endif
            end else begin
              uart_txd <= shift_q[1];
            end
          end
        end
`ifdef GSM_UART_TX_PARITY_EN
        PARITY: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= STOP;
            uart_txd <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (pop) begin
              shift_q  <= rd_data;
`ifdef GSM_UART_TX_PARITY_EN
              parity_q <= ^rd_data;
`endif
              bit_cnt  <= '0;
              state    <= START;
              uart_txd <= 1'b0;
            end else begin
              state    <= IDLE;
              uart_txd <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          uart_txd <= 1'b1;
          baud_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gsm_uart_tx.sv
// Bench for gsm_uart_tx: line waveform built from the frame format, plus a UART
// receiver model that decodes the line and is compared against the bytes written.
module tb_gsm_uart_tx;

  localparam int unsigned CLK_DIV    = 16;
  localparam int unsigned FIFO_DEPTH = 4;
`ifdef GSM_UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_txd;
  logic       busy;
  logic       overflow;

  int tests_run = 0;
  int tests_failed = 0;

  gsm_uart_tx #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_txd(uart_txd), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rst_events = 0;
  always @(negedge rst_n) rst_events <= rst_events + 1;

  int ovf_seen = 0;
  always @(negedge clk) if (overflow === 1'b1) ovf_seen <= ovf_seen + 1;

  typedef struct {
    logic [7:0] data;
    int         start;
    logic       par;
    logic       stop;
  } rx_t;

  rx_t rx_q[$];

  // Receiver model: detect start, sample mid-bit, discard frames cut by a reset
  initial begin : monitor
    rx_t  e;
    int   ev;
    logic ok;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && uart_txd === 1'b0) begin
        e.start = cyc;
        ev = rst_events;
        ok = 1'b1;
        repeat (CLK_DIV / 2) @(negedge clk);
        if (uart_txd !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          e.data[i] = uart_txd;
        end
        e.par = 1'b0;
`ifdef GSM_UART_TX_PARITY_EN
        repeat (CLK_DIV) @(negedge clk);
        e.par = uart_txd;
`endif
        repeat (CLK_DIV) @(negedge clk);
        e.stop = uart_txd;
        if (ok && ev == rst_events && rst_n === 1'b1) rx_q.push_back(e);
      end
    end
  end

  // Expected line level at offset off cycles into a frame carrying byte b
  function automatic logic exp_line(input logic [7:0] b, input int off);
    int idx;
    idx = off / CLK_DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef GSM_UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((busy !== 1'b0) && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_rx(input int n, input int limit);
    int k;
    k = 0;
    while (rx_q.size() < n && k < limit) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tx_valid = 1'b0;
    repeat (3) tick();
    tests_run++; if (uart_txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd got %b expected 1", uart_txd); end
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b expected 1", tx_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b expected 0", busy); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b expected 0", overflow); end
    rst_n = 1'b1;
    repeat (2) tick();
    tests_run++; if (uart_txd !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release txd=%b busy=%b expected txd=1 busy=0", uart_txd, busy); end
  endtask

  task automatic test_single_byte();
    logic exp_b;
    wait_idle(4 * FRAME);
    rx_q.delete();
    write_byte(8'h41);
    for (int k = 1; k <= FRAME + 1; k++) begin
      tick();
      tests_run++;
      if (uart_txd !== exp_line(8'h41, k - 1)) begin tests_failed++; $display("FAIL single_txd edge %0d got %b expected %b", k, uart_txd, exp_line(8'h41, k - 1)); end
      exp_b = (k <= FRAME);
      tests_run++;
      if (busy !== exp_b) begin tests_failed++; $display("FAIL single_busy edge %0d got %b expected %b", k, busy, exp_b); end
    end
    tests_run++;
    if (rx_q.size() != 1 || rx_q[0].data !== 8'h41 || rx_q[0].stop !== 1'b1) begin
      tests_failed++; $display("FAIL single_rx got %0d frames expected one 0x41 frame", rx_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic exp_l;
    logic exp_b;
    wait_idle(4 * FRAME);
    rx_q.delete();
    write_byte(8'h55);
    write_byte(8'hAA);
    for (int k = 2; k <= 2 * FRAME + 1; k++) begin
      tick();
      exp_l = (k - 1 < FRAME) ? exp_line(8'h55, k - 1) : exp_line(8'hAA, k - 1 - FRAME);
      tests_run++;
      if (uart_txd !== exp_l) begin tests_failed++; $display("FAIL b2b_txd edge %0d got %b expected %b", k, uart_txd, exp_l); end
      exp_b = (k <= 2 * FRAME);
      tests_run++;
      if (busy !== exp_b) begin tests_failed++; $display("FAIL b2b_busy edge %0d got %b expected %b", k, busy, exp_b); end
    end
    tests_run++;
    if (rx_q.size() != 2) begin
      tests_failed++; $display("FAIL b2b_rx_count got %0d expected 2", rx_q.size());
    end else begin
      tests_run++;
      if (rx_q[0].data !== 8'h55 || rx_q[1].data !== 8'hAA) begin tests_failed++; $display("FAIL b2b_rx_data got %h %h expected 55 aa", rx_q[0].data, rx_q[1].data); end
      tests_run++;
      if (rx_q[1].start - rx_q[0].start != FRAME) begin tests_failed++; $display("FAIL b2b_gap got %0d expected %0d", rx_q[1].start - rx_q[0].start, FRAME); end
    end
  endtask

`ifdef GSM_UART_TX_PARITY_EN
  task automatic test_parity();
    wait_idle(4 * FRAME);
    rx_q.delete();
    write_byte(8'h07);
    write_byte(8'h03);
    wait_rx(2, 3 * FRAME);
    tests_run++;
    if (rx_q.size() != 2) begin
      tests_failed++; $display("FAIL parity_rx_count got %0d expected 2", rx_q.size());
    end else begin
      tests_run++;
      if (rx_q[0].par !== 1'b1) begin tests_failed++; $display("FAIL parity_07 got %b expected 1", rx_q[0].par); end
      tests_run++;
      if (rx_q[1].par !== 1'b0) begin tests_failed++; $display("FAIL parity_03 got %b expected 0", rx_q[1].par); end
      tests_run++;
      if (rx_q[1].start - rx_q[0].start != 11 * CLK_DIV) begin tests_failed++; $display("FAIL parity_frame_len got %0d expected %0d", rx_q[1].start - rx_q[0].start, 11 * CLK_DIV); end
    end
  endtask
`endif

  task automatic test_overflow();
    logic [7:0] b [6];
    logic       exp_r;
    logic       exp_o;
    wait_idle(4 * FRAME);
    rx_q.delete();
    for (int i = 0; i < 6; i++) b[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      tx_valid = 1'b1;
      tx_data  = b[i];
      tick();
      exp_r = (i < FIFO_DEPTH);
      exp_o = (i == 5);
      tests_run++;
      if (tx_ready !== exp_r) begin tests_failed++; $display("FAIL ovf_ready edge %0d got %b expected %b", i, tx_ready, exp_r); end
      tests_run++;
      if (overflow !== exp_o) begin tests_failed++; $display("FAIL ovf_pulse edge %0d got %b expected %b", i, overflow, exp_o); end
    end
    tx_valid = 1'b0;
    tick();
    tests_run++;
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_pulse_len got %b expected 0", overflow); end
    wait_rx(5, 7 * FRAME);
    tests_run++;
    if (rx_q.size() != 5) begin
      tests_failed++; $display("FAIL ovf_rx_count got %0d expected 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (rx_q[i].data !== b[i]) begin tests_failed++; $display("FAIL ovf_rx_data[%0d] got %h expected %h", i, rx_q[i].data, b[i]); end
      end
    end
    wait_idle(4 * FRAME);
    tests_run++;
    if (rx_q.size() != 5) begin tests_failed++; $display("FAIL ovf_dropped got %0d frames expected 5", rx_q.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b0;
    int         bad;
    wait_idle(4 * FRAME);
    rx_q.delete();
    b0 = 8'($urandom);
    write_byte(b0);
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    repeat (4 * CLK_DIV + 6) tick();
    tests_run++;
    if (busy !== 1'b1 || uart_txd !== b0[3]) begin tests_failed++; $display("FAIL rstmid_before busy=%b txd=%b expected busy=1 txd=%b", busy, uart_txd, b0[3]); end
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++; if (uart_txd !== 1'b1) begin tests_failed++; $display("FAIL rstmid_txd got %b expected 1", uart_txd); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got %b expected 0", busy); end
    tests_run++; if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready got %b expected 1", tx_ready); end
    repeat (3) tick();
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      tick();
      if (uart_txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin tests_failed++; $display("FAIL rstmid_resume got %0d active cycles expected 0", bad); end
    tests_run++;
    if (rx_q.size() != 0) begin tests_failed++; $display("FAIL rstmid_rx got %0d frames expected 0", rx_q.size()); end
  endtask

  // Streams bytes honouring tx_ready with random idle gaps; checks order and no overflow
  task automatic stream_check(input string name, input logic [7:0] bytes_q[$], input int max_gap);
    int ovf0;
    int n;
    wait_idle(6 * FRAME);
    rx_q.delete();
    ovf0 = ovf_seen;
    foreach (bytes_q[i]) begin
      repeat ($urandom_range(0, max_gap)) tick();
      n = 0;
      while (tx_ready !== 1'b1 && n < 2 * FRAME) begin tick(); n++; end
      tests_run++;
      if (tx_ready !== 1'b1) begin tests_failed++; $display("FAIL %s_ready_timeout byte %0d got %b expected 1", name, i, tx_ready); end
      write_byte(bytes_q[i]);
    end
    wait_rx(bytes_q.size(), (bytes_q.size() + 2) * FRAME);
    tests_run++;
    if (rx_q.size() != bytes_q.size()) begin
      tests_failed++; $display("FAIL %s_rx_count got %0d expected %0d", name, rx_q.size(), bytes_q.size());
    end else begin
      foreach (bytes_q[i]) begin
        tests_run++;
        if (rx_q[i].data !== bytes_q[i] || rx_q[i].stop !== 1'b1) begin
          tests_failed++; $display("FAIL %s_rx[%0d] got %h stop %b expected %h stop 1", name, i, rx_q[i].data, rx_q[i].stop, bytes_q[i]);
        end
`ifdef GSM_UART_TX_PARITY_EN
        tests_run++;
        if (rx_q[i].par !== ^bytes_q[i]) begin tests_failed++; $display("FAIL %s_par[%0d] got %b expected %b", name, i, rx_q[i].par, ^bytes_q[i]); end
`endif
      end
    end
    tests_run++;
    if (ovf_seen != ovf0) begin tests_failed++; $display("FAIL %s_overflow got %0d pulses expected 0", name, ovf_seen - ovf0); end
  endtask

  task automatic test_sequencer();
    string      s;
    logic [7:0] q[$];
    s = "AT+CMGF=1\r\n";
    for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
    stream_check("seq", q, 3);
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    for (int i = 0; i < 20; i++) q.push_back(8'($urandom));
    stream_check("rand", q, FRAME / 3);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
`ifdef GSM_UART_TX_PARITY_EN
    test_parity();
`endif
    test_overflow();
    test_reset_mid_frame();
    test_sequencer();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
